star_mem_arbiter: RTL and testbench

Arbiter and sequencer for the single-port 160x120 image memory (15-bit address, 3-bit colour) shared by the star-finding engines: cleaner, square drawer, row/column mapper and pixel scanner. Each cycle it grants at most one requester, and supports locked bursts so one engine can own the memory across a multi-beat operation. It drives the registered memory port, range-checks addresses against the 19200-pixel frame, and routes 1-cycle-latency read data back to the requester that issued the read. It sits between the scan/map/draw/clean engines and the frame-buffer RAM.

---
 rtl/star_mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_star_mem_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/star_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : star_mem_arbiter                                             |
// | Description : Single-port frame-buffer arbiter/sequencer for the star      |
// |               engines, with locked bursts and read-data return routing.    |
// |               Define ARB_ROUND_ROBIN_EN for round-robin arbitration;       |
// |               fixed priority (index 0 highest) otherwise.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module star_mem_arbiter #(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 3,
  parameter int N_REQ     = 4,
  parameter int MEM_DEPTH = 19200
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ-1:0]        req_lock,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    mem_wren,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    err_addr
);

  localparam int              c_sel_w     = 2;
  localparam logic [0:0]      c_st_idle   = 1'b0;
  localparam logic [0:0]      c_st_locked = 1'b1;
  localparam logic [ADDR_W-1:0] c_depth   = ADDR_W'(MEM_DEPTH);

  logic [0:0]         r_state, w_state_nxt;
  logic [c_sel_w-1:0] r_owner, w_owner_nxt;

  logic [ADDR_W-1:0]  w_addr  [N_REQ];
  logic [DATA_W-1:0]  w_wdata [N_REQ];

  logic               w_any;
  logic [c_sel_w-1:0] w_winner;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;
  logic               w_sel_we, w_sel_lock, w_in_range;

  logic               r_tag1_vld, r_tag1_ok, r_tag2_vld, r_tag2_ok;
  logic [c_sel_w-1:0] r_tag1_req, r_tag2_req;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign w_wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

`ifdef ARB_ROUND_ROBIN_EN
  logic [c_sel_w-1:0] r_ptr, w_ptr_nxt, w_rr_idx;
  logic               w_release;
`endif

  // Winner selection; a locked owner bypasses arbitration entirely.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
`ifdef ARB_ROUND_ROBIN_EN
    w_rr_idx = '0;
`endif
    if (r_state == c_st_locked) begin
      w_any    = req[r_owner];
      w_winner = r_owner;
    end else begin
`ifdef ARB_ROUND_ROBIN_EN
      for (int k = N_REQ - 1; k >= 0; k--) begin
        w_rr_idx = r_ptr + c_sel_w'(k);
        if (req[w_rr_idx]) begin
          w_any    = 1'b1;
          w_winner = w_rr_idx;
        end
      end
`else
      for (int k = N_REQ - 1; k >= 0; k--) begin
        if (req[k]) begin
          w_any    = 1'b1;
          w_winner = c_sel_w'(k);
        end
      end
`endif
    end
  end

  assign w_sel_addr  = w_addr[w_winner];
  assign w_sel_wdata = w_wdata[w_winner];
  assign w_sel_we    = req_we[w_winner];
  assign w_sel_lock  = req_lock[w_winner];
  assign w_in_range  = (w_sel_addr < c_depth);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_idle;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Ownership ends on an accepted non-lock beat, or when a locked owner drops req.
  assign w_release = w_any ? ~w_sel_lock : (r_state == c_st_locked);
  assign w_ptr_nxt = w_release ? (w_winner + 2'd1) : r_ptr;

  always_ff @(posedge clk) begin
    if (reset) r_ptr <= '0;
    else       r_ptr <= w_ptr_nxt;
  end
`endif

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    case (r_state)
      c_st_idle: begin
        if (w_any && w_sel_lock) begin
          w_state_nxt = c_st_locked;
          w_owner_nxt = w_winner;
        end
      end
      c_st_locked: begin
        if (!w_any || !w_sel_lock) w_state_nxt = c_st_idle;
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  // Output logic
  always_comb begin
    gnt    = '0;
    rvalid = '0;
    rdata  = '0;
    if (!reset) begin
      if (w_any) gnt[w_winner] = 1'b1;
      if (r_tag2_vld) begin
        rvalid[r_tag2_req] = 1'b1;
        if (r_tag2_ok) rdata = mem_rdata;
      end
    end
  end

  // Memory port and read-tag pipeline aligned to the RAM's one-cycle latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wren   <= 1'b0;
      err_addr   <= 1'b0;
      r_tag1_vld <= 1'b0;
      r_tag1_req <= '0;
      r_tag1_ok  <= 1'b0;
      r_tag2_vld <= 1'b0;
      r_tag2_req <= '0;
      r_tag2_ok  <= 1'b0;
    end else begin
      mem_wren <= 1'b0;
      if (w_any) begin
        mem_addr  <= w_sel_addr;
        mem_wdata <= w_sel_wdata;
        mem_wren  <= w_sel_we & w_in_range;
        if (!w_in_range) err_addr <= 1'b1;
      end
      r_tag1_vld <= w_any & ~w_sel_we;
      r_tag1_req <= w_winner;
      r_tag1_ok  <= w_in_range;
      r_tag2_vld <= r_tag1_vld;
      r_tag2_req <= r_tag1_req;
      r_tag2_ok  <= r_tag1_ok;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_star_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_star_mem_arbiter                                          |
// | Description : Directed bench for star_mem_arbiter with a read-before-write |
// |               RAM model on the memory port.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_star_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req, req_we, req_lock;
  logic [59:0] req_addr;
  logic [11:0] req_wdata;
  logic [3:0]  gnt, rvalid;
  logic [2:0]  rdata, mem_wdata, mem_rdata;
  logic [14:0] mem_addr;
  logic        mem_wren, err_addr;

  logic [2:0]  ram [0:32767];
  int          n_total = 0;
  int          n_bad   = 0;
  logic [3:0]  exp_cont [5];
  logic [3:0]  exp_b4, exp_b5;

  star_mem_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_rdata(mem_rdata), .err_addr(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-before-write RAM with one cycle of read latency.
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_wren) ram[mem_addr] <= mem_wdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_req(input int i, input logic we, input logic lk, input int addr, input int data);
    req[i]                 = 1'b1;
    req_we[i]              = we;
    req_lock[i]            = lk;
    req_addr[i*15 +: 15]   = 15'(addr);
    req_wdata[i*3 +: 3]    = 3'(data);
  endtask

  task automatic clr_req(input int i);
    req[i]      = 1'b0;
    req_we[i]   = 1'b0;
    req_lock[i] = 1'b0;
  endtask

  task automatic clr_all();
    req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr_all();
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    exp_cont = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_b4 = 4'b1000; exp_b5 = 4'b0001;
`else
    exp_cont = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    exp_b4 = 4'b0001; exp_b5 = 4'b1000;
`endif
    for (int a = 0; a < 32768; a++) ram[a] = 3'd0;
    ram[15'h0141] = 3'd5;
    ram[19205]    = 3'd7;
    mem_rdata = 3'd0;

    // Reset state, with all requesters asserting
    reset = 1'b1;
    clr_all();
    req = 4'b1111;
    step();
    mid();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_rvalid", rvalid, 4'b0000);
    chk("rst_rdata", rdata, 3'd0);
    chk("rst_mem_addr", mem_addr, 15'd0);
    chk("rst_mem_wdata", mem_wdata, 3'd0);
    chk("rst_mem_wren", mem_wren, 1'b0);
    chk("rst_err", err_addr, 1'b0);
    step();
    reset = 1'b0;
    clr_all();
    idle(1);

    // Single read by the scanner
    set_req(3, 1'b0, 1'b0, 'h141, 0);
    mid(); chk("rd_gnt", gnt, 4'b1000);
    step(); clr_all();
    mid(); chk("rd_mem_addr", mem_addr, 15'h0141); chk("rd_wren", mem_wren, 1'b0);
    chk("rd_rvalid_early", rvalid, 4'b0000);
    step();
    mid(); chk("rd_rvalid", rvalid, 4'b1000); chk("rd_rdata", rdata, 3'd5);
    idle(3);

    // Contention, all non-lock reads held
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b0, 10 + i, 0);
    for (int c = 0; c < 5; c++) begin
      mid();
      chk($sformatf("cont_gnt%0d", c), gnt, exp_cont[c]);
      if (c == 1) chk("cont_mem_addr", mem_addr, 15'd10);
      step();
    end
    clr_req(0);
    mid(); chk("cont_drop0_gnt", gnt, 4'b0010);
    step(); clr_all();
    idle(3);

    // Locked drawer burst against cleaner and scanner
    do_reset();
    set_req(1, 1'b1, 1'b1, 100, 1);
    set_req(3, 1'b0, 1'b0, 'h141, 0);
    mid(); chk("burst_b0_gnt", gnt, 4'b0010);
    step(); set_req(1, 1'b1, 1'b1, 101, 2); set_req(0, 1'b0, 1'b0, 200, 0);
    mid(); chk("burst_b1_gnt", gnt, 4'b0010); chk("burst_b1_wren", mem_wren, 1'b1);
    chk("burst_b1_addr", mem_addr, 15'd100); chk("burst_b1_wdata", mem_wdata, 3'd1);
    step(); set_req(1, 1'b1, 1'b1, 102, 3);
    mid(); chk("burst_b2_gnt", gnt, 4'b0010); chk("burst_b2_wren", mem_wren, 1'b1);
    step(); set_req(1, 1'b1, 1'b0, 103, 4);
    mid(); chk("burst_b3_gnt", gnt, 4'b0010); chk("burst_b3_wren", mem_wren, 1'b1);
    step(); clr_req(1);
    mid(); chk("burst_b4_gnt", gnt, exp_b4); chk("burst_b4_wren", mem_wren, 1'b1);
    chk("burst_b4_addr", mem_addr, 15'd103); chk("burst_b4_wdata", mem_wdata, 3'd4);
    step();
    if (exp_b4 == 4'b0001) clr_req(0); else clr_req(3);
    mid(); chk("burst_b5_gnt", gnt, exp_b5); chk("burst_b5_wren", mem_wren, 1'b0);
    step(); clr_all();
    idle(3);

    // Read then write of the same address, then read back
    set_req(0, 1'b0, 1'b0, 102, 0);
    mid(); chk("rbw_rd_gnt", gnt, 4'b0001);
    step(); set_req(0, 1'b1, 1'b0, 102, 6);
    mid(); chk("rbw_wr_gnt", gnt, 4'b0001);
    step(); set_req(0, 1'b0, 1'b0, 102, 0);
    mid(); chk("rbw_rvalid", rvalid, 4'b0001); chk("rbw_old_data", rdata, 3'd3);
    chk("rbw_wren", mem_wren, 1'b1);
    step(); clr_all();
    mid(); chk("rbw_no_rvalid_wr", rvalid, 4'b0000);
    step();
    mid(); chk("rbw_rvalid2", rvalid, 4'b0001); chk("rbw_new_data", rdata, 3'd6);
    idle(3);

    // Range boundary and out-of-range accesses
    set_req(0, 1'b1, 1'b0, 19199, 2);
    mid(); chk("oor_last_gnt", gnt, 4'b0001);
    step(); set_req(0, 1'b1, 1'b0, 19200, 7);
    mid(); chk("oor_last_wren", mem_wren, 1'b1); chk("oor_last_addr", mem_addr, 15'd19199);
    chk("oor_err_pre", err_addr, 1'b0); chk("oor_gnt", gnt, 4'b0001);
    step(); set_req(0, 1'b0, 1'b0, 19205, 0);
    mid(); chk("oor_wren", mem_wren, 1'b0); chk("oor_err", err_addr, 1'b1);
    chk("oor_rd_gnt", gnt, 4'b0001);
    step(); clr_all();
    mid(); chk("oor_err_sticky", err_addr, 1'b1); chk("oor_wr_no_rvalid", rvalid, 4'b0000);
    step();
    mid(); chk("oor_rvalid", rvalid, 4'b0001); chk("oor_rdata", rdata, 3'd0);
    idle(3);

    // Reset in the middle of a locked read sequence
    set_req(1, 1'b0, 1'b1, 5, 0);
    mid(); chk("rstm_l0_gnt", gnt, 4'b0010);
    step(); set_req(1, 1'b0, 1'b1, 6, 0); set_req(0, 1'b0, 1'b0, 7, 0);
    mid(); chk("rstm_lock_gnt", gnt, 4'b0010);
    step(); reset = 1'b1; clr_req(1); set_req(3, 1'b0, 1'b0, 8, 0);
    mid(); chk("rstm_gnt_in_reset", gnt, 4'b0000);
    step(); reset = 1'b0;
    mid();
    chk("rstm_rvalid", rvalid, 4'b0000);
    chk("rstm_rdata", rdata, 3'd0);
    chk("rstm_mem_addr", mem_addr, 15'd0);
    chk("rstm_mem_wren", mem_wren, 1'b0);
    chk("rstm_mem_wdata", mem_wdata, 3'd0);
    chk("rstm_err", err_addr, 1'b0);
    chk("rstm_lock_gone_gnt", gnt, 4'b0001);
    step(); clr_all();
    idle(3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
